rr_dispatcher: RTL and testbench

RR_DISPATCHER -- requirements
Module: rr_dispatcher

---
 rtl/rr_dispatch_pkg.sv | 20 ++
 rtl/rr_pick.sv | 24 ++
 rtl/rr_dispatcher.sv | 118 +++++++++++
 tb/tb_rr_dispatcher.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/rr_dispatch_pkg.sv
// Shared defaults and the one-hot rotate helper for the round-robin credit dispatcher.
package rr_dispatch_pkg;

   localparam int unsigned DefArbiterWidth = 8;
   localparam int unsigned DefDataWidth    = 32;
   localparam int unsigned DefCreditWidth  = 4;
   localparam int unsigned DefInitCredits  = 4;

   // Widest vector rr_rotl1 can handle; callers cast in and out of this width.
   localparam int unsigned RrMaxWidth = 64;

   // Rotate a w-bit one-hot left by one, bit w-1 wrapping to bit 0.
   function automatic logic [RrMaxWidth-1:0] rr_rotl1(input logic [RrMaxWidth-1:0] v,
                                                      input int unsigned           w);
      logic [RrMaxWidth-1:0] mask;
      mask = (w >= RrMaxWidth) ? '1 : ((RrMaxWidth'(1) << w) - RrMaxWidth'(1));
      return ((v << 1) | (v >> (w - 1))) & mask;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: first eligible bit at or above the one-hot pointer, wrapping.
module rr_pick #(
   parameter int unsigned width = 8
) (
   input  logic [width-1:0] pointer,
   input  logic [width-1:0] eligible,
   output logic [width-1:0] grant,
   output logic             any
);

   logic [width-1:0] upper;
   logic [width-1:0] upper_first;
   logic [width-1:0] all_first;

   always_comb begin
      // pointer is one-hot, so pointer-1 masks off the bits strictly below it
      upper       = eligible & ~(pointer - width'(1));
      upper_first = upper & (~upper + width'(1));
      all_first   = eligible & (~eligible + width'(1));
      grant       = (upper != '0) ? upper_first : all_first;
      any         = |eligible;
   end

endmodule

// File: rtl/rr_dispatcher.sv
// Credit-based round-robin task dispatcher with one-cycle dispatch latency.
// Define RR_DISPATCH_ERR_EN to add the sticky o_err credit-overflow flag.
module rr_dispatcher
   import rr_dispatch_pkg::*;
#(
   parameter int unsigned arbiter_width = DefArbiterWidth,
   parameter int unsigned data_width    = DefDataWidth,
   parameter int unsigned credit_width  = DefCreditWidth,
   parameter int unsigned init_credits  = DefInitCredits
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   input  logic [data_width-1:0]    i_data,
   output logic                     o_ready,
   output logic [arbiter_width-1:0] o_valid,
   output logic [data_width-1:0]    o_data,
   input  logic [arbiter_width-1:0] i_credit_ret
`ifdef RR_DISPATCH_ERR_EN
   ,
   output logic                     o_err
`endif
);

   localparam logic [credit_width-1:0] CreditMax  = '1;
   localparam logic [credit_width-1:0] CreditInit = credit_width'(init_credits);

   logic [credit_width-1:0]  credit_q [arbiter_width];
   logic [credit_width-1:0]  credit_d [arbiter_width];
   logic [arbiter_width-1:0] ptr_q;
   logic [arbiter_width-1:0] ptr_d;
   logic [arbiter_width-1:0] valid_q;
   logic [data_width-1:0]    data_q;
   logic [arbiter_width-1:0] eligible;
   logic [arbiter_width-1:0] grant;
   logic [arbiter_width-1:0] dispatch;
   logic                     any;
   logic                     accept;

   always_comb begin
      eligible = '0;
      for (int k = 0; k < arbiter_width; k++) begin
         eligible[k] = (credit_q[k] != '0);
      end
   end

   rr_pick #(
      .width(arbiter_width)
   ) u_pick (
      .pointer (ptr_q),
      .eligible(eligible),
      .grant   (grant),
      .any     (any)
   );

   // Credits are not yet loaded while reset is held, so readiness follows the reset value.
   assign o_ready  = i_rst ? (init_credits != 0) : any;
   assign accept   = i_valid & o_ready & ~i_rst;
   assign dispatch = grant & {arbiter_width{accept}};
   assign ptr_d    = accept ? arbiter_width'(rr_rotl1(RrMaxWidth'(grant), arbiter_width)) : ptr_q;

   always_comb begin
      for (int k = 0; k < arbiter_width; k++) begin
         credit_d[k] = credit_q[k];
         if (dispatch[k] && !i_credit_ret[k]) begin
            credit_d[k] = credit_q[k] - credit_width'(1);
         end else if (!dispatch[k] && i_credit_ret[k] && (credit_q[k] != CreditMax)) begin
            credit_d[k] = credit_q[k] + credit_width'(1);
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         ptr_q   <= arbiter_width'(1);
         valid_q <= '0;
         data_q  <= '0;
         for (int k = 0; k < arbiter_width; k++) begin
            credit_q[k] <= CreditInit;
         end
      end else begin
         ptr_q   <= ptr_d;
         valid_q <= dispatch;
         if (accept) begin
            data_q <= i_data;
         end
         for (int k = 0; k < arbiter_width; k++) begin
            credit_q[k] <= credit_d[k];
         end
      end
   end

   assign o_valid = valid_q;
   assign o_data  = data_q;

`ifdef RR_DISPATCH_ERR_EN
   logic [arbiter_width-1:0] ret_ignored;
   logic                     err_q;

   always_comb begin
      ret_ignored = '0;
      for (int k = 0; k < arbiter_width; k++) begin
         ret_ignored[k] = i_credit_ret[k] & ~dispatch[k] & (credit_q[k] == CreditMax);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         err_q <= 1'b0;
      end else if (|ret_ignored) begin
         err_q <= 1'b1;
      end
   end

   assign o_err = err_q;
`endif

endmodule

// File: tb/tb_rr_dispatcher.sv
// Self-checking bench for rr_dispatcher: vector table plus directed credit/reset sequences.
module tb_rr_dispatcher;

   logic        i_clk;
   logic        i_rst;
   logic        i_valid;
   logic [31:0] i_data;
   logic        o_ready;
   logic [7:0]  o_valid;
   logic [31:0] o_data;
   logic [7:0]  i_credit_ret;
`ifdef RR_DISPATCH_ERR_EN
   logic        o_err;
`endif

   rr_dispatcher dut (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_valid     (i_valid),
      .i_data      (i_data),
      .o_ready     (o_ready),
      .o_valid     (o_valid),
      .o_data      (o_data),
      .i_credit_ret(i_credit_ret)
`ifdef RR_DISPATCH_ERR_EN
      ,
      .o_err       (o_err)
`endif
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   typedef struct {
      logic [31:0] data;
      logic [7:0]  exp_valid;
   } vec_t;

   typedef struct {
      logic [7:0]  valid;
      logic [31:0] data;
   } exp_t;

   vec_t        vecs [8];
   exp_t        sb [$];
   logic [31:0] held;
   int          checks;
   int          errors;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Drive one cycle, queue the expected registered outputs, then compare after the edge.
   task automatic cycle(input logic v, input logic [31:0] d, input logic [7:0] ret,
                        input logic rst, input logic [7:0] exp_v, input string name);
      exp_t e;
      i_valid      = v;
      i_data       = d;
      i_credit_ret = ret;
      i_rst        = rst;
      e.valid = exp_v;
      if (rst) e.data = 32'h0;
      else if (exp_v != 8'h0) e.data = d;
      else e.data = held;
      held = e.data;
      sb.push_back(e);
      @(posedge i_clk);
      #1;
      e = sb.pop_front();
      chk({name, " o_valid"}, 64'(o_valid), 64'(e.valid));
      chk({name, " o_data"}, 64'(o_data), 64'(e.data));
   endtask

   task automatic chk_credits(input logic [3:0] exp, input string name);
      for (int k = 0; k < 8; k++) begin
         chk($sformatf("%s credit[%0d]", name, k), 64'(dut.credit_q[k]), 64'(exp));
      end
   endtask

   task automatic do_reset();
      cycle(1'b0, 32'h0, 8'h00, 1'b1, 8'h00, "reset");
   endtask

   // From reset (pointer at bit 0, all credits 4) 32 tasks visit workers 0..7 four times.
   task automatic drain32();
      for (int i = 0; i < 32; i++) begin
         cycle(1'b1, 32'hD000_0000 + 32'(i), 8'h00, 1'b0, 8'(1 << (i % 8)), "drain");
      end
      chk("drained o_ready", 64'(o_ready), 64'd0);
   endtask

   initial begin
      checks       = 0;
      errors       = 0;
      held         = 32'h0;
      i_rst        = 1'b1;
      i_valid      = 1'b0;
      i_data       = 32'h0;
      i_credit_ret = 8'h00;

      vecs = '{'{32'hA000_0000, 8'h01}, '{32'hA111_0001, 8'h02},
               '{32'hA222_0002, 8'h04}, '{32'hA333_0003, 8'h08},
               '{32'hA444_0004, 8'h10}, '{32'hA555_0005, 8'h20},
               '{32'hA666_0006, 8'h40}, '{32'hA777_0007, 8'h80}};

      // Reset state
      #1;
      chk("o_ready during reset", 64'(o_ready), 64'd1);
      do_reset();
      chk("o_ready after reset", 64'(o_ready), 64'd1);
      chk("pointer after reset", 64'(dut.ptr_q), 64'h01);
      chk_credits(4'd4, "reset");
`ifdef RR_DISPATCH_ERR_EN
      chk("o_err after reset", 64'(o_err), 64'd0);
`endif

      // Back-to-back round robin across all workers
      for (int i = 0; i < 8; i++) begin
         cycle(1'b1, vecs[i].data, 8'h00, 1'b0, vecs[i].exp_valid, $sformatf("rr[%0d]", i));
      end
      cycle(1'b0, 32'hFFFF_FFFF, 8'h00, 1'b0, 8'h00, "idle hold");
      chk_credits(4'd3, "after rr");

      // Exhaust credits, then one return on w5 re-enables only the following cycle
      do_reset();
      drain32();
      chk_credits(4'd0, "drained");
      cycle(1'b1, 32'h5555_0000, 8'h20, 1'b0, 8'h00, "ret w5 same cycle");
      chk("o_ready after w5 return", 64'(o_ready), 64'd1);
      cycle(1'b1, 32'h5555_0001, 8'h00, 1'b0, 8'h20, "task to w5");
      chk("o_ready after w5 task", 64'(o_ready), 64'd0);

      // w0/w1 starved, pointer at bit 0: grant skips to w2, pointer moves to bit 3
      do_reset();
      drain32();
      for (int i = 0; i < 4; i++) begin
         cycle(1'b0, 32'h0, 8'hFC, 1'b0, 8'h00, "refill w2..w7");
      end
      chk("pointer before skip", 64'(dut.ptr_q), 64'h01);
      cycle(1'b1, 32'h3636_0000, 8'h00, 1'b0, 8'h04, "skip to w2");
      chk("pointer after skip", 64'(dut.ptr_q), 64'h08);
      cycle(1'b1, 32'h3636_0001, 8'h00, 1'b0, 8'h08, "next to w3");

      // Dispatch and return on w3 in the same cycle leave its credit unchanged
      do_reset();
      drain32();
      cycle(1'b0, 32'h0, 8'h08, 1'b0, 8'h00, "ret w3");
      cycle(1'b1, 32'h3838_0000, 8'h08, 1'b0, 8'h08, "w3 dispatch+ret");
      chk("credit[3] after dispatch+ret", 64'(dut.credit_q[3]), 64'd1);
      chk("o_ready w3 credit 1", 64'(o_ready), 64'd1);
      cycle(1'b1, 32'h3838_0001, 8'h00, 1'b0, 8'h08, "w3 last credit");
      chk("o_ready w3 credit 0", 64'(o_ready), 64'd0);

      // Saturation on w2 at max credit
      do_reset();
      for (int i = 0; i < 11; i++) begin
         cycle(1'b0, 32'h0, 8'h04, 1'b0, 8'h00, "fill w2");
      end
      chk("credit[2] at max", 64'(dut.credit_q[2]), 64'd15);
`ifdef RR_DISPATCH_ERR_EN
      chk("o_err before overflow", 64'(o_err), 64'd0);
`endif
      cycle(1'b0, 32'h0, 8'h04, 1'b0, 8'h00, "overflow w2");
      chk("credit[2] saturated", 64'(dut.credit_q[2]), 64'd15);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 32'h0, 8'h00, 1'b0, 8'h00, "post overflow idle");
`ifdef RR_DISPATCH_ERR_EN
         chk("o_err sticky", 64'(o_err), 64'd1);
`endif
      end
      do_reset();
`ifdef RR_DISPATCH_ERR_EN
      chk("o_err cleared by reset", 64'(o_err), 64'd0);
`endif
      chk("credit[2] after reset", 64'(dut.credit_q[2]), 64'd4);

      // Reset coincident with a valid task drops the task
      for (int i = 0; i < 3; i++) begin
         cycle(1'b1, 32'h4040_0000 + 32'(i), 8'h00, 1'b0, 8'(1 << i), "pre-reset task");
      end
      cycle(1'b1, 32'h4040_00FF, 8'h00, 1'b1, 8'h00, "task during reset");
      chk_credits(4'd4, "reset over accept");
      chk("pointer reset over accept", 64'(dut.ptr_q), 64'h01);
      cycle(1'b1, 32'h4040_0100, 8'h00, 1'b0, 8'h01, "first after reset");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
